// File: rtl/mdio_phy_mgmt_ctrl.sv
// -----------------------------------------------------------------------------
// mdio_phy_mgmt_ctrl
//
// Management controller for the board's GMII PHY. After reset it holds the
// PHY hard reset (gmii_rstn) low for RST_HOLD clocks, then accepts register
// access requests and runs one IEEE 802.3 Clause-22 MDIO frame per request.
// MDC is generated from sys0_clk; MDD is driven/released through an external
// IOBUF (mdio_mdd_o / mdio_mdd_oe / mdio_mdd_i).
//
// Ports
//   sys0_clk, sys0_rst       clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake (accept on valid && ready)
//   req_write                1 = write, 0 = read
//   req_phyad, req_regad     5-bit PHY and register address
//   req_wdata                16-bit write data (ignored on reads)
//   rsp_valid                one-cycle pulse when a frame completes
//   rsp_rdata, rsp_err       read data / turnaround error, held until next rsp
//   busy                     controller not idle
//   gmii_rstn                PHY hard reset, active low
//   mdio_mdc                 MDC
//   mdio_mdd_o, mdio_mdd_oe  MDD drive value and enable (0 = released)
//   mdio_mdd_i               MDD sampled input
// -----------------------------------------------------------------------------
module mdio_phy_mgmt_ctrl #(
    parameter int CLK_DIV  = 25,
    parameter int RST_HOLD = 1250000
) (
    input  logic        sys0_clk,
    input  logic        sys0_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [4:0]  req_phyad,
    input  logic [4:0]  req_regad,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        gmii_rstn,
    output logic        mdio_mdc,
    output logic        mdio_mdd_o,
    output logic        mdio_mdd_oe,
    input  logic        mdio_mdd_i
);

    localparam int DW = (CLK_DIV  > 1) ? $clog2(CLK_DIV)  : 1;
    localparam int RW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [RW-1:0] RST_LAST = RW'(RST_HOLD - 1);

    typedef enum logic [1:0] {
        S_RST_HOLD,
        S_IDLE,
        S_FRAME,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [RW-1:0] rst_cnt_q;
    logic [DW-1:0] div_q;
    logic          hi_q;        // 0 = MDC low half of the bit, 1 = high half
    logic [5:0]    bit_q;       // bit index within the 64-bit frame
    logic [63:0]   frame_q;     // remaining bits still to be driven, MSB next
    logic          wr_q;
    logic [15:0]   rdata_sh_q;
    logic          ta_err_q;
    logic          gmii_rstn_q;
    logic          mdc_q;
    logic          mdd_o_q;
    logic          mdd_oe_q;
    logic          ready_q;
    logic          rsp_valid_q;
    logic [15:0]   rsp_rdata_q;
    logic          rsp_err_q;
    logic          busy_q;

    logic [63:0]   frame_load_d;
    logic [5:0]    bit_nxt_d;
    logic          oe_nxt_d;

    // Full frame image for the incoming request. On reads the TA and data
    // positions are filled with ones so mdd_o idles high while released.
    always_comb begin
        frame_load_d = {32'hFFFF_FFFF, 2'b01,
                        req_write ? 2'b01 : 2'b10,
                        req_phyad, req_regad,
                        req_write ? 2'b10 : 2'b11,
                        req_write ? req_wdata : 16'hFFFF};
        bit_nxt_d    = bit_q + 6'd1;
        // Reads release the line from the first TA bit (bit 46) onward.
        oe_nxt_d     = wr_q || (bit_nxt_d < 6'd46);
    end

    always_ff @(posedge sys0_clk or posedge sys0_rst) begin
        if (sys0_rst) begin
            state_q     <= S_RST_HOLD;
            rst_cnt_q   <= '0;
            div_q       <= '0;
            hi_q        <= 1'b0;
            bit_q       <= '0;
            frame_q     <= '0;
            wr_q        <= 1'b0;
            rdata_sh_q  <= '0;
            ta_err_q    <= 1'b0;
            gmii_rstn_q <= 1'b0;
            mdc_q       <= 1'b0;
            mdd_o_q     <= 1'b1;
            mdd_oe_q    <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                S_RST_HOLD: begin
                    if (rst_cnt_q == RST_LAST) begin
                        gmii_rstn_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end

                S_IDLE: begin
                    mdc_q <= 1'b0;
                    if (req_valid && ready_q) begin
                        // First bit is presented in the first FRAME cycle.
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        wr_q       <= req_write;
                        mdd_o_q    <= frame_load_d[63];
                        mdd_oe_q   <= 1'b1;
                        frame_q    <= {frame_load_d[62:0], 1'b0};
                        div_q      <= '0;
                        hi_q       <= 1'b0;
                        bit_q      <= '0;
                        rdata_sh_q <= '0;
                        ta_err_q   <= 1'b0;
                        state_q    <= S_FRAME;
                    end else begin
                        ready_q  <= 1'b1;
                        mdd_oe_q <= 1'b0;
                    end
                end

                S_FRAME: begin
                    if (div_q != DIV_LAST) begin
                        div_q <= div_q + 1'b1;
                    end else begin
                        div_q <= '0;
                        if (!hi_q) begin
                            // MDC rising: capture the line for this bit.
                            hi_q  <= 1'b1;
                            mdc_q <= 1'b1;
                            if (bit_q == 6'd47 && !wr_q && mdio_mdd_i)
                                ta_err_q <= 1'b1;
                            if (bit_q >= 6'd48)
                                rdata_sh_q <= {rdata_sh_q[14:0], mdio_mdd_i};
                        end else begin
                            hi_q  <= 1'b0;
                            mdc_q <= 1'b0;
                            if (bit_q == 6'd63) begin
                                mdd_oe_q    <= 1'b0;
                                mdd_o_q     <= 1'b1;
                                rsp_valid_q <= 1'b1;
                                rsp_rdata_q <= wr_q ? 16'h0000 : rdata_sh_q;
                                rsp_err_q   <= !wr_q && ta_err_q;
                                state_q     <= S_DONE;
                            end else begin
                                bit_q    <= bit_nxt_d;
                                mdd_o_q  <= frame_q[63];
                                mdd_oe_q <= oe_nxt_d;
                                frame_q  <= {frame_q[62:0], 1'b0};
                            end
                        end
                    end
                end

                S_DONE: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = busy_q;
    assign gmii_rstn   = gmii_rstn_q;
    assign mdio_mdc    = mdc_q;
    assign mdio_mdd_o  = mdd_o_q;
    assign mdio_mdd_oe = mdd_oe_q;

endmodule

// File: tb/tb_mdio_phy_mgmt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mdio_phy_mgmt_ctrl
//
// Scoreboard bench: the stimulus process pushes an expected response (built
// from the frame format rules) when a request is accepted; the monitor pops
// and compares on each rsp_valid. A behavioural PHY answers read frames.
// -----------------------------------------------------------------------------
module tb_mdio_phy_mgmt_ctrl;

    localparam int CLK_DIV  = 2;
    localparam int RST_HOLD = 100;
    localparam int LAT      = 128 * CLK_DIV + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid, req_ready, req_write;
    logic [4:0]  req_phyad, req_regad;
    logic [15:0] req_wdata;
    logic        rsp_valid, rsp_err, busy, gmii_rstn;
    logic [15:0] rsp_rdata;
    logic        mdc, mdd_o, mdd_oe, mdd_i;
    logic        phy_drv = 1'b1;

    always #5 clk = ~clk;

    // Open-drain style bus: released line reads back as the PHY drive or pull-up.
    assign mdd_i = mdd_oe ? mdd_o : phy_drv;

    mdio_phy_mgmt_ctrl #(.CLK_DIV(CLK_DIV), .RST_HOLD(RST_HOLD)) dut (
        .sys0_clk   (clk),
        .sys0_rst   (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_phyad  (req_phyad),
        .req_regad  (req_regad),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .gmii_rstn  (gmii_rstn),
        .mdio_mdc   (mdc),
        .mdio_mdd_o (mdd_o),
        .mdio_mdd_oe(mdd_oe),
        .mdio_mdd_i (mdd_i)
    );

    typedef struct {
        logic [63:0] frame;
        logic [63:0] oe;
        logic [15:0] rdata;
        logic        err;
        logic        wr;
        logic        present;
        logic        ta_bad;
        logic [15:0] pdata;
    } exp_t;

    exp_t        exp_q[$];
    int          acc_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mon_bit = 0;
    logic [15:0] last_rdata = 16'h0;
    logic        last_err = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: what the frame on the wire and the response must be.
    function automatic exp_t model(input bit w, input logic [4:0] p, input logic [4:0] r,
                                   input logic [15:0] d, input bit present, input bit ta_bad,
                                   input logic [15:0] pdata);
        exp_t e;
        logic [15:0] rd;
        logic ta2;
        rd        = present ? pdata : 16'hFFFF;
        ta2       = present ? ta_bad : 1'b1;
        e.wr      = w;
        e.present = present;
        e.ta_bad  = ta_bad;
        e.pdata   = pdata;
        if (w) begin
            e.frame = {32'hFFFF_FFFF, 2'b01, 2'b01, p, r, 2'b10, d};
            e.oe    = '1;
            e.rdata = 16'h0;
            e.err   = 1'b0;
        end else begin
            e.frame = {32'hFFFF_FFFF, 2'b01, 2'b10, p, r, 1'b1, ta2, rd};
            e.oe    = {{46{1'b1}}, 18'b0};
            e.rdata = rd;
            e.err   = ta2;
        end
        return e;
    endfunction

    // PHY behaviour for bit k of the current frame (1 = released / pulled up).
    function automatic logic phy_val(input int k, input exp_t e);
        if (e.wr || !e.present) return 1'b1;
        if (k == 47) return e.ta_bad;
        if (k >= 48 && k <= 63) return e.pdata[63-k];
        return 1'b1;
    endfunction

    // Monitor + PHY, sampled on the falling clock edge.
    initial begin
        exp_t e;
        logic [63:0] line_vec, oe_vec;
        logic prev_mdc;
        int a;
        prev_mdc = 1'b0;
        line_vec = '0;
        oe_vec   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_mdc   = 1'b0;
                mon_bit    = 0;
                phy_drv    = 1'b1;
                last_rdata = 16'h0;
                last_err   = 1'b0;
            end else begin
                chk("ready_and_busy", 64'(busy & req_ready), 64'd0);
                if (req_valid && req_ready) begin
                    acc_q.push_back(cyc);
                    mon_bit  = 0;
                    line_vec = '0;
                    oe_vec   = '0;
                    chk("hold_rdata", 64'(rsp_rdata), 64'(last_rdata));
                    chk("hold_err", 64'(rsp_err), 64'(last_err));
                    chk("idle_mdc_oe", 64'({mdc, mdd_oe}), 64'd0);
                end
                if (mdc && !prev_mdc) begin
                    if (mon_bit < 64) begin
                        line_vec[63-mon_bit] = mdd_i;
                        oe_vec[63-mon_bit]   = mdd_oe;
                    end
                    mon_bit++;
                end
                if (!mdc && prev_mdc && exp_q.size() > 0)
                    phy_drv = phy_val(mon_bit, exp_q[0]);
                if (rsp_valid) begin
                    if (exp_q.size() == 0 || acc_q.size() == 0) begin
                        chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        a = acc_q.pop_front();
                        chk("latency", 64'(cyc - a), 64'(LAT));
                        chk("bit_count", 64'(mon_bit), 64'd64);
                        chk("frame_bits", line_vec, e.frame);
                        chk("oe_pattern", oe_vec, e.oe);
                        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                        chk("rsp_err", 64'(rsp_err), 64'(e.err));
                        last_rdata = e.rdata;
                        last_err   = e.err;
                    end
                    phy_drv = 1'b1;
                end
                prev_mdc = mdc;
            end
        end
    end

    // Entered and left at posedge+1.
    task automatic issue(input bit w, input logic [4:0] p, input logic [4:0] r,
                         input logic [15:0] d, input bit present, input bit ta_bad,
                         input logic [15:0] pdata, input bit keep, output int acc);
        int n = 0;
        req_write = w;
        req_phyad = p;
        req_regad = r;
        req_wdata = d;
        req_valid = 1'b1;
        acc = -1;
        forever begin
            @(negedge clk);
            if (req_ready) begin
                exp_q.push_back(model(w, p, r, d, present, ta_bad, pdata));
                acc = cyc;
                break;
            end
            n++;
            if (n > 4 * LAT) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: no req_ready within %0d cycles", n);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!keep) req_valid = 1'b0;
    endtask

    // Expects rst already high; releases it and checks the hold period.
    task automatic reset_seq();
        int n0 = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_gmii_rstn", 64'(gmii_rstn), 64'd0);
        chk("rst_mdc", 64'(mdc), 64'd0);
        chk("rst_oe", 64'(mdd_oe), 64'd0);
        chk("rst_mdd_o", 64'(mdd_o), 64'd1);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        forever begin
            @(negedge clk);
            if (gmii_rstn) break;
            n0++;
            if (n0 > RST_HOLD + 20) break;
        end
        chk("rst_hold_cycles", 64'(n0), 64'(RST_HOLD));
        chk("ready_at_rstn_rise", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("ready_after_hold", 64'(req_ready), 64'd1);
        chk("busy_after_hold", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int accA, accB, n, gap;
        bit w, pres, tab, keep;
        logic [4:0] p, r;
        logic [15:0] d, pd;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_phyad = '0;
        req_regad = '0;
        req_wdata = '0;

        reset_seq();

        // Directed: write 0x1140, read 0x0141, read with no PHY.
        issue(1'b1, 5'd7, 5'd0, 16'h1140, 1'b0, 1'b0, 16'h0, 1'b0, accA);
        issue(1'b0, 5'd7, 5'd2, 16'h0, 1'b1, 1'b0, 16'h0141, 1'b0, accA);
        issue(1'b0, 5'd7, 5'd2, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, accA);

        // Back-to-back with valid held high across the first frame.
        issue(1'b1, 5'd3, 5'd4, 16'hA5A5, 1'b0, 1'b0, 16'h0, 1'b1, accA);
        issue(1'b0, 5'd9, 5'd17, 16'h0, 1'b1, 1'b0, 16'h8001, 1'b0, accB);
        chk("b2b_accept_gap", 64'(accB - accA), 64'(LAT + 1));

        for (int i = 0; i < 24; i++) begin
            w    = 1'($urandom_range(0, 1));
            p    = 5'($urandom());
            r    = 5'($urandom());
            d    = 16'($urandom());
            pres = ($urandom_range(0, 9) < 7);
            tab  = ($urandom_range(0, 9) == 0);
            pd   = 16'($urandom());
            keep = ($urandom_range(0, 3) == 0);
            issue(w, p, r, d, pres, tab, pd, keep, accA);
            gap = int'($urandom_range(0, 4));
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        req_valid = 1'b0;

        // Reset in the middle of a write frame.
        issue(1'b1, 5'd1, 5'd31, 16'hFFFF, 1'b0, 1'b0, 16'h0, 1'b0, accA);
        n = 0;
        while (mon_bit < 41 && n < 4 * LAT) begin
            @(posedge clk);
            n++;
        end
        chk("abort_reached_bit40", 64'(mon_bit >= 41), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("abort_oe", 64'(mdd_oe), 64'd0);
        chk("abort_mdc", 64'(mdc), 64'd0);
        chk("abort_gmii_rstn", 64'(gmii_rstn), 64'd0);
        chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        exp_q.delete();
        acc_q.delete();
        reset_seq();

        issue(1'b0, 5'd0, 5'd1, 16'h0, 1'b1, 1'b0, 16'h796D, 1'b0, accA);
        issue(1'b1, 5'd31, 5'd22, 16'h0003, 1'b0, 1'b0, 16'h0, 1'b0, accA);

        n = 0;
        while (exp_q.size() != 0 && n < 4 * LAT) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
